// File: rtl/bcd_stopwatch_core_if.sv
// rtl/bcd_stopwatch_core_if.sv - command, status and display signal bundle for bcd_stopwatch_core
//
// Purpose: groups the controller-facing commands, the status/count outputs and
//          the 7-segment display outputs of the stopwatch core.
// Signals:
//   en, start, stop, clear, load, load_val, down, lap  commands into the core
//   running, expired, wrap, count_bcd                   status out of the core
//   seg, dp, an                                         display drive, active-low
// Modports: master drives commands and observes status; slave is the core.
interface bcd_stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    down;
    logic                    lap;
    logic                    running;
    logic                    expired;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output en, start, stop, clear, load, load_val, down, lap,
        input  running, expired, wrap, count_bcd, seg, dp, an
    );

    modport slave (
        input  en, start, stop, clear, load, load_val, down, lap,
        output running, expired, wrap, count_bcd, seg, dp, an
    );
endinterface

// File: rtl/bcd_stopwatch_core.sv
// rtl/bcd_stopwatch_core.sv - BCD stopwatch/countdown timer with multiplexed 7-segment driver
//
// Purpose: N-digit BCD up/down counter stepped by a prescaler, with run/pause
//          control, preset load, lap display hold, expiry, and a scanned
//          7-segment display of either the live or the held count.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous, active-high
//   bus    slave modport of bcd_stopwatch_core_if (commands, status, display)
module bcd_stopwatch_core #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter int SCAN_BITS  = 16,
    parameter int DP_POS     = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    bcd_stopwatch_core_if.slave    bus
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_q, dir_d;
    logic            hold_q, hold_d;
    logic [W-1:0]    disp_q, disp_d;
    logic            wrap_q, wrap_d;
    logic [SCAN_BITS-1:0] scan_q;
    logic [IW-1:0]   idx_q;

    logic [W-1:0]    up_val;
    logic            up_all9;
    logic [W-1:0]    dn_val;
    logic [W-1:0]    sat_val;
    logic            count_zero;
    logic            dn_zero;
    logic            carry;
    logic            borrow;

    // BCD ripple increment: a digit only changes while a carry reaches it.
    // A carry surviving past the top digit means every digit was 9.
    always_comb begin
        up_val = count_q;
        carry  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    up_val[4*i +: 4] = 4'd0;
                end else begin
                    up_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        up_all9 = carry;
    end

    // BCD ripple decrement; only used when the count is non-zero.
    always_comb begin
        dn_val = count_q;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dn_val[4*i +: 4] = 4'd9;
                end else begin
                    dn_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
    end

    // Preset digits above 9 are clamped so the count always holds valid BCD.
    always_comb begin
        sat_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sat_val[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
        end
    end

    assign count_zero = (count_q == '0);
    assign dn_zero    = (dn_val == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            hold_q  <= 1'b0;
            disp_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
        end
    end

    // Command priority: clear > load > stop > start. Lap is independent of
    // stop/start but is dropped whenever clear or an accepted load wins.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        disp_d  = disp_q;
        wrap_d  = 1'b0;

        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
            hold_d  = 1'b0;
        end else if (bus.load && (state_q != ST_RUN)) begin
            state_d = (state_q == ST_PAUSED) ? ST_PAUSED : ST_IDLE;
            count_d = sat_val;
            presc_d = '0;
            hold_d  = 1'b0;
        end else begin
            if (bus.lap && ((state_q == ST_RUN) || (state_q == ST_PAUSED))) begin
                hold_d = ~hold_q;
                if (!hold_q) begin
                    disp_d = count_q;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        dir_d   = bus.down;
                        presc_d = '0;
                        state_d = (bus.down && count_zero) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSED;
                    end else if (bus.en) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (!dir_q) begin
                                count_d = up_val;
                                wrap_d  = up_all9;
                            end else begin
                                // Never borrow below zero; a zero result expires.
                                if (!count_zero) begin
                                    count_d = dn_val;
                                end
                                if (count_zero || dn_zero) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    // Prescaler is left alone so the partial tick resumes.
                    if (bus.start && !bus.stop) begin
                        state_d = (dir_q && count_zero) ? ST_DONE : ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display scan: the digit index advances each time the scan counter wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_q + SCAN_BITS'(1);
            if (scan_q == {SCAN_BITS{1'b1}}) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end
    end

    logic [W-1:0]          shown;
    logic [3:0]            digit;
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] an_c;

    always_comb begin
        shown = hold_q ? disp_q : count_q;
        digit = 4'd0;
        an_c  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                digit   = shown[4*i +: 4];
                an_c[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (digit)
            4'd0:    seg_c = 7'h40;
            4'd1:    seg_c = 7'h79;
            4'd2:    seg_c = 7'h24;
            4'd3:    seg_c = 7'h30;
            4'd4:    seg_c = 7'h19;
            4'd5:    seg_c = 7'h12;
            4'd6:    seg_c = 7'h02;
            4'd7:    seg_c = 7'h78;
            4'd8:    seg_c = 7'h00;
            4'd9:    seg_c = 7'h10;
            default: seg_c = 7'h3F;
        endcase
    end

    assign bus.running   = (state_q == ST_RUN);
    assign bus.expired   = (state_q == ST_DONE);
    assign bus.wrap      = wrap_q;
    assign bus.count_bcd = count_q;
    assign bus.seg       = seg_c;
    assign bus.an        = an_c;
    assign bus.dp        = (int'(idx_q) == DP_POS) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// tb/tb_bcd_stopwatch_core.sv - self-checking bench for bcd_stopwatch_core
module tb_bcd_stopwatch_core;

    localparam int ND = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    bcd_stopwatch_core_if #(.NUM_DIGITS(ND)) bus_if ();

    bcd_stopwatch_core #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (4),
        .SCAN_BITS (2),
        .DP_POS    (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: count kept as a plain integer, state as a small code
    // (0 idle, 1 run, 2 paused, 3 done), scan position as cycles since reset.
    int m_state;
    int m_val;
    int m_presc;
    int m_disp;
    int m_scan;
    bit m_dir;
    bit m_hold;
    bit m_wrap;

    logic [6:0] seg_tab [10];

    function automatic int pow10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int sat_int(input logic [15:0] lv);
        int r = 0;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * pow10(i);
        end
        return r;
    endfunction

    function automatic int exp_idx();
        return (m_scan / 4) % ND;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one = 4'b0001;
        return ~(one << exp_idx());
    endfunction

    function automatic logic [6:0] exp_seg();
        int v = m_hold ? m_disp : m_val;
        return seg_tab[(v / pow10(exp_idx())) % 10];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_val   = 0;
        m_presc = 0;
        m_disp  = 0;
        m_scan  = 0;
        m_dir   = 1'b0;
        m_hold  = 1'b0;
        m_wrap  = 1'b0;
    endtask

    // Advance the model across the coming clock edge, take the edge, then
    // drop the one-cycle command pulses.
    task automatic cyc();
        bit nw;
        nw = 1'b0;
        if (bus_if.clear) begin
            m_state = 0; m_val = 0; m_presc = 0; m_hold = 1'b0;
        end else if (bus_if.load && m_state != 1) begin
            m_state = (m_state == 2) ? 2 : 0;
            m_val   = sat_int(bus_if.load_val);
            m_presc = 0;
            m_hold  = 1'b0;
        end else begin
            if (bus_if.lap && (m_state == 1 || m_state == 2)) begin
                if (!m_hold) m_disp = m_val;
                m_hold = !m_hold;
            end
            case (m_state)
                0: if (bus_if.start && !bus_if.stop) begin
                    m_dir   = bus_if.down;
                    m_presc = 0;
                    m_state = (bus_if.down && m_val == 0) ? 3 : 1;
                end
                1: if (bus_if.stop) begin
                    m_state = 2;
                end else if (bus_if.en) begin
                    if (m_presc == 3) begin
                        m_presc = 0;
                        if (!m_dir) begin
                            if (m_val == 9999) begin m_val = 0; nw = 1'b1; end
                            else m_val = m_val + 1;
                        end else begin
                            if (m_val > 0) m_val = m_val - 1;
                            if (m_val == 0) m_state = 3;
                        end
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
                2: if (bus_if.start && !bus_if.stop) m_state = (m_dir && m_val == 0) ? 3 : 1;
                default: ;
            endcase
        end
        m_wrap = nw;
        m_scan = m_scan + 1;
        @(posedge clock);
        @(negedge clock);
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.clear = 1'b0;
        bus_if.load  = 1'b0;
        bus_if.lap   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e_an;
        logic [3:0] one;
        bit         e_dp;
        repeat (2) @(negedge clock);
        n_checks++; if (bus_if.count_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h want 0000", bus_if.count_bcd); end
        n_checks++; if (bus_if.running !== 1'b0 || bus_if.expired !== 1'b0 || bus_if.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_status got r%b e%b w%b want 000", bus_if.running, bus_if.expired, bus_if.wrap); end
        n_checks++; if (bus_if.an !== 4'b1110) begin n_fail++; $display("FAIL reset_an got %b want 1110", bus_if.an); end
        model_reset();
        reset = 1'b0;
        one = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            e_an = ~(one << ((k / 4) % 4));
            e_dp = ((k / 4) % 4) != 3;
            n_checks++; if (bus_if.an !== e_an) begin n_fail++; $display("FAIL scan_an k=%0d got %b want %b", k, bus_if.an, e_an); end
            n_checks++; if (bus_if.dp !== e_dp) begin n_fail++; $display("FAIL scan_dp k=%0d got %b want %b", k, bus_if.dp, e_dp); end
            n_checks++; if (bus_if.seg !== 7'h40) begin n_fail++; $display("FAIL scan_seg k=%0d got %h want 40", k, bus_if.seg); end
            cyc();
        end
    endtask

    task automatic test_count_up();
        bus_if.clear = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        n_checks++; if (bus_if.running !== 1'b1) begin n_fail++; $display("FAIL up_running got %b want 1", bus_if.running); end
        repeat (3) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0000) begin n_fail++; $display("FAIL up_e3 got %h want 0000", bus_if.count_bcd); end
        cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0001) begin n_fail++; $display("FAIL up_e4 got %h want 0001", bus_if.count_bcd); end
        repeat (4) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0002) begin n_fail++; $display("FAIL up_e8 got %h want 0002", bus_if.count_bcd); end
        bus_if.en = 1'b0;
        repeat (10) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0002) begin n_fail++; $display("FAIL en_freeze got %h want 0002", bus_if.count_bcd); end
        bus_if.en = 1'b1;
        repeat (3) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0002) begin n_fail++; $display("FAIL en_resume3 got %h want 0002", bus_if.count_bcd); end
        cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0003) begin n_fail++; $display("FAIL en_resume4 got %h want 0003", bus_if.count_bcd); end
    endtask

    task automatic test_wrap();
        bus_if.clear = 1'b1; cyc();
        bus_if.load_val = 16'h0999; bus_if.load = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        repeat (4) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h1000) begin n_fail++; $display("FAIL carry_0999 got %h want 1000", bus_if.count_bcd); end
        bus_if.clear = 1'b1; cyc();
        bus_if.load_val = 16'h9999; bus_if.load = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        repeat (3) cyc();
        n_checks++; if (bus_if.wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_early got %b want 0", bus_if.wrap); end
        cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0000 || bus_if.wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_edge got %h w%b want 0000 w1", bus_if.count_bcd, bus_if.wrap); end
        cyc();
        n_checks++; if (bus_if.wrap !== 1'b0 || bus_if.running !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got w%b r%b want w0 r1", bus_if.wrap, bus_if.running); end
    endtask

    task automatic test_down();
        bus_if.clear = 1'b1; cyc();
        bus_if.down = 1'b1;
        bus_if.load_val = 16'h0002; bus_if.load = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        repeat (4) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0001 || bus_if.running !== 1'b1) begin n_fail++; $display("FAIL down_step1 got %h r%b want 0001 r1", bus_if.count_bcd, bus_if.running); end
        repeat (4) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0000 || bus_if.expired !== 1'b1 || bus_if.running !== 1'b0) begin n_fail++; $display("FAIL down_done got %h e%b r%b want 0000 e1 r0", bus_if.count_bcd, bus_if.expired, bus_if.running); end
        bus_if.start = 1'b1; bus_if.lap = 1'b1; cyc();
        repeat (5) cyc();
        n_checks++; if (bus_if.expired !== 1'b1 || bus_if.count_bcd !== 16'h0000) begin n_fail++; $display("FAIL done_ignores got e%b %h want e1 0000", bus_if.expired, bus_if.count_bcd); end
        bus_if.clear = 1'b1; cyc();
        n_checks++; if (bus_if.expired !== 1'b0 || bus_if.running !== 1'b0) begin n_fail++; $display("FAIL done_clear got e%b r%b want e0 r0", bus_if.expired, bus_if.running); end
        bus_if.start = 1'b1; cyc();
        n_checks++; if (bus_if.expired !== 1'b1) begin n_fail++; $display("FAIL down_start_zero got e%b want 1", bus_if.expired); end
        bus_if.clear = 1'b1; cyc();
        bus_if.down = 1'b0;
    endtask

    task automatic test_pause();
        bus_if.clear = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        repeat (2) cyc();
        bus_if.start = 1'b1; bus_if.stop = 1'b1; cyc();
        n_checks++; if (bus_if.running !== 1'b0) begin n_fail++; $display("FAIL start_stop_pause got r%b want 0", bus_if.running); end
        repeat (5) cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0000) begin n_fail++; $display("FAIL paused_hold got %h want 0000", bus_if.count_bcd); end
        bus_if.start = 1'b1; cyc();
        cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0000 || bus_if.running !== 1'b1) begin n_fail++; $display("FAIL resume_s1 got %h r%b want 0000 r1", bus_if.count_bcd, bus_if.running); end
        cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0001) begin n_fail++; $display("FAIL resume_s2 got %h want 0001", bus_if.count_bcd); end
        bus_if.stop = 1'b1; cyc();
        bus_if.load_val = 16'h00A3; bus_if.load = 1'b1; cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h0093 || bus_if.running !== 1'b0) begin n_fail++; $display("FAIL load_sat got %h r%b want 0093 r0", bus_if.count_bcd, bus_if.running); end
        bus_if.load_val = 16'hFAB7; bus_if.load = 1'b1; cyc();
        n_checks++; if (bus_if.count_bcd !== 16'h9997) begin n_fail++; $display("FAIL load_sat_all got %h want 9997", bus_if.count_bcd); end
        bus_if.start = 1'b1; cyc();
        n_checks++; if (bus_if.running !== 1'b1) begin n_fail++; $display("FAIL paused_load_resume got r%b want 1", bus_if.running); end
    endtask

    task automatic test_lap();
        logic [6:0] e;
        bus_if.clear = 1'b1; cyc();
        bus_if.load_val = 16'h0005; bus_if.load = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        bus_if.lap = 1'b1; cyc();
        for (int k = 0; k < 15; k++) begin
            e = (exp_idx() == 0) ? 7'h12 : 7'h40;
            n_checks++; if (bus_if.seg !== e) begin n_fail++; $display("FAIL lap_hold k=%0d got %h want %h", k, bus_if.seg, e); end
            cyc();
        end
        n_checks++; if (bus_if.count_bcd !== 16'h0009) begin n_fail++; $display("FAIL lap_live got %h want 0009", bus_if.count_bcd); end
        bus_if.lap = 1'b1; bus_if.stop = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            e = (exp_idx() == 0) ? 7'h10 : 7'h40;
            n_checks++; if (bus_if.seg !== e) begin n_fail++; $display("FAIL lap_release k=%0d got %h want %h", k, bus_if.seg, e); end
            cyc();
        end
    endtask

    task automatic test_reset_midrun();
        bus_if.clear = 1'b1; cyc();
        bus_if.start = 1'b1; cyc();
        repeat (9) cyc();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus_if.count_bcd !== 16'h0000 || bus_if.running !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got %h r%b want 0000 r0", bus_if.count_bcd, bus_if.running); end
        n_checks++; if (bus_if.an !== 4'b1110) begin n_fail++; $display("FAIL midrun_reset_an got %b want 1110", bus_if.an); end
        @(negedge clock);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] lv;
        for (int n = 0; n < 4000; n++) begin
            n_checks++; if (bus_if.count_bcd !== to_bcd(m_val)) begin n_fail++; $display("FAIL rnd_count n=%0d got %h want %h", n, bus_if.count_bcd, to_bcd(m_val)); end
            n_checks++; if (bus_if.running !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_running n=%0d got %b want %b", n, bus_if.running, (m_state == 1)); end
            n_checks++; if (bus_if.expired !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_expired n=%0d got %b want %b", n, bus_if.expired, (m_state == 3)); end
            n_checks++; if (bus_if.wrap !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap n=%0d got %b want %b", n, bus_if.wrap, m_wrap); end
            n_checks++; if (bus_if.an !== exp_an()) begin n_fail++; $display("FAIL rnd_an n=%0d got %b want %b", n, bus_if.an, exp_an()); end
            n_checks++; if (bus_if.dp !== (exp_idx() != 3)) begin n_fail++; $display("FAIL rnd_dp n=%0d got %b want %b", n, bus_if.dp, (exp_idx() != 3)); end
            n_checks++; if (bus_if.seg !== exp_seg()) begin n_fail++; $display("FAIL rnd_seg n=%0d got %h want %h", n, bus_if.seg, exp_seg()); end
            bus_if.en    = ($urandom_range(0, 7) != 0);
            bus_if.start = ($urandom_range(0, 7) == 0);
            bus_if.stop  = ($urandom_range(0, 15) == 0);
            bus_if.clear = ($urandom_range(0, 99) == 0);
            bus_if.load  = ($urandom_range(0, 31) == 0);
            bus_if.lap   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) bus_if.down = ~bus_if.down;
            case ($urandom_range(0, 2))
                0: lv = 16'($urandom);
                1: lv = to_bcd($urandom_range(0, 9999));
                default: lv = to_bcd($urandom_range(0, 12));
            endcase
            bus_if.load_val = lv;
            cyc();
        end
    endtask

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        bus_if.en       = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        bus_if.clear    = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.load_val = '0;
        bus_if.down     = 1'b0;
        bus_if.lap      = 1'b0;
        model_reset();

        test_reset();
        test_count_up();
        test_wrap();
        test_down();
        test_pause();
        test_lap();
        test_reset_midrun();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
